// File: rtl/pipeline_step_ctrl_if.sv
// Command/status bundle between the debug unit and the run/step controller.
// The debug unit drives commands (master); the controller answers (slave).
interface pipeline_step_ctrl_if #(
    parameter int CNT_WIDTH  = 32,
    parameter int STEP_WIDTH = 8
);
    logic                  i_run_cmd;
    logic                  i_step_cmd;
    logic [STEP_WIDTH-1:0] i_step_n;
    logic                  i_stop_cmd;
    logic                  i_clear_cmd;
    logic                  i_halt_wb;
    logic                  o_enable;
    logic                  o_halted;
    logic                  o_step_done;
    logic [CNT_WIDTH-1:0]  o_cycle_count;
    logic [2:0]            o_state;

    modport master (
        output i_run_cmd, i_step_cmd, i_step_n, i_stop_cmd, i_clear_cmd, i_halt_wb,
        input  o_enable, o_halted, o_step_done, o_cycle_count, o_state
    );

    modport slave (
        input  i_run_cmd, i_step_cmd, i_step_n, i_stop_cmd, i_clear_cmd, i_halt_wb,
        output o_enable, o_halted, o_step_done, o_cycle_count, o_state
    );
endinterface

// File: rtl/pipeline_step_ctrl.sv
// Run/step controller: generates the global pipeline/PC enable, stops on a
// retired HALT, and counts enabled cycles for the debug unit.
//
// state  | meaning
// IDLE   | pipeline frozen, waiting for run/step; clear zeroes the counter
// RUN    | free-running until stop or HALT in WB
// STEP   | enabled for a fixed number of cycles held in rem_q
// HALTED | HALT retired; frozen until clear
module pipeline_step_ctrl #(
    parameter int CNT_WIDTH  = 32,
    parameter int STEP_WIDTH = 8
) (
    input logic                 i_clock,
    input logic                 i_reset,
    pipeline_step_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [STEP_WIDTH-1:0] rem_q, rem_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  clr_cnt;
    logic                  enable;

    // Enable is decoded from the state register only, so it never glitches
    // on command inputs.
    assign enable = (state_q == RUN) || (state_q == STEP);

    // State, remaining-step counter and done pulse registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. HALT in WB is only trusted in enabled states because
    // a frozen WB stage holds stale data.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        clr_cnt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_run_cmd) begin
                    state_d = RUN;
                end else if (bus.i_step_cmd) begin
                    state_d = STEP;
                    rem_d   = (bus.i_step_n == '0) ? STEP_WIDTH'(1) : bus.i_step_n;
                end
                if (bus.i_clear_cmd) begin
                    clr_cnt = 1'b1;
                end
            end
            RUN: begin
                if (bus.i_halt_wb) begin
                    state_d = HALTED;
                end else if (bus.i_stop_cmd) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                rem_d = rem_q - STEP_WIDTH'(1);
                if (bus.i_halt_wb) begin
                    state_d = HALTED;
                    rem_d   = '0;
                    done_d  = 1'b1;
                end else if (rem_q == STEP_WIDTH'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            HALTED: begin
                if (bus.i_clear_cmd) begin
                    state_d = IDLE;
                    clr_cnt = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating enabled-cycle counter. Clear is only accepted while the
    // enable is low, so the two never collide.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (enable && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.o_enable      = enable;
    assign bus.o_halted      = (state_q == HALTED);
    assign bus.o_step_done   = done_q;
    assign bus.o_cycle_count = cnt_q;
    assign bus.o_state       = {1'b0, state_q};

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Bench for pipeline_step_ctrl: vector table, directed corner sequences and
// random commands checked against a budget-based reference model.
module tb_pipeline_step_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_step_ctrl_if #(.CNT_WIDTH(32), .STEP_WIDTH(8)) bus ();
    pipeline_step_ctrl_if #(.CNT_WIDTH(4),  .STEP_WIDTH(8)) sbus ();

    pipeline_step_ctrl #(.CNT_WIDTH(32), .STEP_WIDTH(8)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    pipeline_step_ctrl #(.CNT_WIDTH(4), .STEP_WIDTH(8)) dut_sat (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (sbus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: budget of enabled cycles left (-1 = unlimited run,
    // 0 = frozen), plus halted flag, done pulse and cycle total.
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;
    int     m_budget;
    bit     m_halted;
    bit     m_done;
    longint m_count;

    task automatic model_reset();
        m_budget = 0;
        m_halted = 0;
        m_done   = 0;
        m_count  = 0;
    endtask

    task automatic model_edge();
        bit enabled;
        enabled = (m_budget != 0);
        m_done  = 0;
        if (enabled && m_count < CMAX) m_count++;
        if (m_halted) begin
            if (bus.i_clear_cmd) begin
                m_halted = 0;
                m_count  = 0;
            end
        end else if (m_budget == 0) begin
            if (bus.i_run_cmd) m_budget = -1;
            else if (bus.i_step_cmd) m_budget = (bus.i_step_n == 0) ? 1 : int'(bus.i_step_n);
            if (bus.i_clear_cmd) m_count = 0;
        end else if (m_budget < 0) begin
            if (bus.i_halt_wb) begin
                m_halted = 1;
                m_budget = 0;
            end else if (bus.i_stop_cmd) begin
                m_budget = 0;
            end
        end else begin
            if (bus.i_halt_wb) begin
                m_halted = 1;
                m_budget = 0;
                m_done   = 1;
            end else begin
                m_budget--;
                if (m_budget == 0) m_done = 1;
            end
        end
    endtask

    function automatic int model_state();
        if (m_halted) return 3;
        if (m_budget < 0) return 1;
        if (m_budget > 0) return 2;
        return 0;
    endfunction

    task automatic model_compare();
        chk("m_enable", bus.o_enable, (m_budget != 0) ? 1 : 0);
        chk("m_state",  bus.o_state, model_state());
        chk("m_halted", bus.o_halted, m_halted);
        chk("m_done",   bus.o_step_done, m_done);
        chk("m_count",  bus.o_cycle_count, m_count);
    endtask

    task automatic drive(input bit run, input bit step, input logic [7:0] n,
                         input bit stop, input bit clear, input bit halt);
        bus.i_run_cmd   = run;
        bus.i_step_cmd  = step;
        bus.i_step_n    = n;
        bus.i_stop_cmd  = stop;
        bus.i_clear_cmd = clear;
        bus.i_halt_wb   = halt;
    endtask

    // One clock: inputs already driven, model advanced, outputs sampled on
    // the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_compare();
    endtask

    task automatic cmd(input bit run, input bit step, input logic [7:0] n,
                       input bit stop, input bit clear, input bit halt);
        drive(run, step, n, stop, clear, halt);
        tick();
        drive(0, 0, 8'd0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 8'd0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         run;
        bit         step;
        logic [7:0] n;
        bit         stop;
        bit         clear;
        bit         halt;
        bit         en;
        int         st;
        bit         hl;
        bit         dn;
        int         cnt;
    } vec_t;

    vec_t tv[18];

    initial begin
        bit seen_done;
        int r;

        drive(0, 0, 8'd0, 0, 0, 0);
        sbus.i_run_cmd   = 0;
        sbus.i_step_cmd  = 0;
        sbus.i_step_n    = 8'd0;
        sbus.i_stop_cmd  = 0;
        sbus.i_clear_cmd = 0;
        sbus.i_halt_wb   = 0;

        //            run stp n     stp clr hlt  en st hl dn cnt
        tv[0]  = '{0, 0, 8'd0, 0, 0, 0,  0, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 8'd3, 0, 0, 0,  1, 2, 0, 0, 0};
        tv[2]  = '{0, 0, 8'd0, 0, 0, 0,  1, 2, 0, 0, 1};
        tv[3]  = '{0, 0, 8'd0, 0, 0, 0,  1, 2, 0, 0, 2};
        tv[4]  = '{0, 0, 8'd0, 0, 0, 0,  0, 0, 0, 1, 3};
        tv[5]  = '{0, 0, 8'd0, 0, 0, 0,  0, 0, 0, 0, 3};
        tv[6]  = '{0, 1, 8'd0, 0, 0, 0,  1, 2, 0, 0, 3};
        tv[7]  = '{0, 0, 8'd0, 0, 0, 0,  0, 0, 0, 1, 4};
        tv[8]  = '{1, 1, 8'd4, 0, 0, 0,  1, 1, 0, 0, 4};
        tv[9]  = '{0, 0, 8'd0, 0, 1, 0,  1, 1, 0, 0, 5};
        tv[10] = '{0, 0, 8'd0, 0, 0, 1,  0, 3, 1, 0, 6};
        tv[11] = '{1, 1, 8'd2, 0, 0, 0,  0, 3, 1, 0, 6};
        tv[12] = '{0, 0, 8'd0, 0, 1, 0,  0, 0, 0, 0, 0};
        tv[13] = '{0, 0, 8'd0, 0, 0, 1,  0, 0, 0, 0, 0};
        tv[14] = '{0, 0, 8'd0, 1, 0, 0,  0, 0, 0, 0, 0};
        tv[15] = '{0, 1, 8'd2, 0, 0, 1,  1, 2, 0, 0, 0};
        tv[16] = '{0, 0, 8'd0, 1, 0, 0,  1, 2, 0, 0, 1};
        tv[17] = '{0, 0, 8'd0, 0, 0, 0,  0, 0, 0, 1, 2};

        // Reset values after release with commands held low.
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_enable", bus.o_enable, 0);
        chk("rst_state",  bus.o_state, 0);
        chk("rst_count",  bus.o_cycle_count, 0);
        chk("rst_halted", bus.o_halted, 0);
        chk("rst_done",   bus.o_step_done, 0);

        // Vector table.
        foreach (tv[i]) begin
            cmd(tv[i].run, tv[i].step, tv[i].n, tv[i].stop, tv[i].clear, tv[i].halt);
            chk($sformatf("tv%0d_enable", i), bus.o_enable, tv[i].en);
            chk($sformatf("tv%0d_state",  i), bus.o_state, tv[i].st);
            chk($sformatf("tv%0d_halted", i), bus.o_halted, tv[i].hl);
            chk($sformatf("tv%0d_done",   i), bus.o_step_done, tv[i].dn);
            chk($sformatf("tv%0d_count",  i), bus.o_cycle_count, tv[i].cnt);
        end

        // Run, stop on the 10th enabled cycle, then resume.
        do_reset();
        cmd(1, 0, 8'd0, 0, 0, 0);
        repeat (9) tick();
        cmd(0, 0, 8'd0, 1, 0, 0);
        chk("stop_enable", bus.o_enable, 0);
        chk("stop_count",  bus.o_cycle_count, 10);
        chk("stop_state",  bus.o_state, 0);
        cmd(1, 0, 8'd0, 0, 0, 0);
        tick();
        chk("resume_count", bus.o_cycle_count, 11);
        cmd(0, 0, 8'd0, 1, 0, 0);

        // HALT on the 7th enabled cycle of a run.
        do_reset();
        cmd(1, 0, 8'd0, 0, 0, 0);
        repeat (6) tick();
        cmd(0, 0, 8'd0, 0, 0, 1);
        chk("halt_halted", bus.o_halted, 1);
        chk("halt_enable", bus.o_enable, 0);
        chk("halt_count",  bus.o_cycle_count, 7);
        cmd(1, 1, 8'd3, 0, 0, 0);
        chk("halt_hold_state", bus.o_state, 3);
        chk("halt_hold_count", bus.o_cycle_count, 7);
        cmd(0, 0, 8'd0, 0, 1, 0);
        chk("clear_state",  bus.o_state, 0);
        chk("clear_count",  bus.o_cycle_count, 0);
        chk("clear_halted", bus.o_halted, 0);

        // HALT on the 2nd enabled cycle of a step of 5.
        do_reset();
        cmd(0, 1, 8'd5, 0, 0, 0);
        tick();
        cmd(0, 0, 8'd0, 0, 0, 1);
        chk("shalt_state", bus.o_state, 3);
        chk("shalt_done",  bus.o_step_done, 1);
        chk("shalt_count", bus.o_cycle_count, 2);
        tick();
        chk("shalt_done_once", bus.o_step_done, 0);
        cmd(0, 0, 8'd0, 0, 1, 0);

        // Asynchronous reset in the middle of a step of 8.
        do_reset();
        cmd(0, 1, 8'd8, 0, 0, 0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset_enable", bus.o_enable, 0);
        chk("areset_state",  bus.o_state, 0);
        chk("areset_count",  bus.o_cycle_count, 0);
        chk("areset_halted", bus.o_halted, 0);
        chk("areset_done",   bus.o_step_done, 0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_step_done) seen_done = 1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            if (bus.o_step_done) seen_done = 1;
        end
        chk("areset_no_done", seen_done, 0);

        // Saturation on the narrow-counter instance.
        do_reset();
        sbus.i_run_cmd = 1;
        @(negedge clk);
        sbus.i_run_cmd = 0;
        repeat (15) @(negedge clk);
        chk("sat_at_max", sbus.o_cycle_count, 15);
        repeat (5) @(negedge clk);
        chk("sat_hold",   sbus.o_cycle_count, 15);
        chk("sat_enable", sbus.o_enable, 1);
        sbus.i_stop_cmd = 1;
        @(negedge clk);
        sbus.i_stop_cmd = 0;
        @(negedge clk);
        chk("sat_stopped", sbus.o_enable, 0);

        // Random commands against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 15));
            drive(r == 0, r == 1, 8'($urandom_range(0, 6)), (r == 2) || (r == 3),
                  r == 4, $urandom_range(0, 19) == 0);
            tick();
        end
        drive(0, 0, 8'd0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
